// File: rtl/pll_phase_scanner_pkg.sv
// Shared types and constants for the PLL phase scanner and its setter-side timing budget.
package pll_phase_scanner_pkg;

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned IDX_W   = 9;

  // Settle time must cover the phase setter's worst-case stepping time.
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 100000;
  localparam int unsigned DEFAULT_WINDOW_CYCLES = 65536;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StMeasure,
    StCompare,
    StFinalApply,
    StFinalSettle,
    StDone
  } state_e;

endpackage

// File: rtl/pll_phase_scanner_score_counter.sv
// Measurement window timer plus saturating hit counter for one phase step.
module pll_phase_scanner_score_counter
  import pll_phase_scanner_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             enable,
  input  logic             hit,
  output logic [CNT_W-1:0] score,
  output logic             window_done
);

  localparam int unsigned TimerW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  score_q, score_d;

  assign window_done = enable && (timer_q == TimerW'(WINDOW_CYCLES - 1));
  assign score       = score_q;

  always_comb begin
    timer_d = timer_q;
    score_d = score_q;
    if (clear) begin
      timer_d = '0;
      score_d = '0;
    end else if (enable) begin
      timer_d = window_done ? '0 : timer_q + TimerW'(1);
      if (hit && (score_q != '1)) begin
        score_d = score_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_q <= '0;
      score_q <= '0;
    end else begin
      timer_q <= timer_d;
      score_q <= score_d;
    end
  end

endmodule

// File: rtl/pll_phase_scanner.sv
// Sweeps PLL phase settings, scores each by data-check hits, then re-applies the best phase.
module pll_phase_scanner
  import pll_phase_scanner_pkg::*;
#(
  parameter int unsigned NSTEPS        = 64,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               clksrc_in,
  input  logic               manual_set,
  input  logic [PHASE_W-1:0] manual_phase,
  input  logic               sample_valid,
  input  logic               sample_ok,
  output logic               update,
  output logic               pll_clksrc,
  output logic [PHASE_W-1:0] pll_phase,
  output logic               busy,
  output logic               done,
  output logic [PHASE_W-1:0] best_phase,
  output logic [CNT_W-1:0]   best_score
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [PHASE_W-1:0]   run_phase_q, run_phase_d;
  logic [CNT_W-1:0]     run_score_q, run_score_d;
  logic                 update_q, update_d;
  logic                 done_q, done_d;
  logic                 clksrc_q, clksrc_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   best_phase_q, best_phase_d;
  logic [CNT_W-1:0]     best_score_q, best_score_d;

  logic                 sc_clear, sc_enable, sc_window_done;
  logic [CNT_W-1:0]     sc_score;
  logic                 settle_last;

  assign settle_last = (settle_q == SettleW'(SETTLE_CYCLES - 1));

  pll_phase_scanner_score_counter #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .CNT_W         (CNT_W)
  ) u_score_counter (
    .clk         (clk),
    .rstn        (rstn),
    .clear       (sc_clear),
    .enable      (sc_enable),
    .hit         (sample_valid && sample_ok),
    .score       (sc_score),
    .window_done (sc_window_done)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    run_phase_d  = run_phase_q;
    run_score_d  = run_score_q;
    update_d     = 1'b0;
    done_d       = 1'b0;
    clksrc_d     = clksrc_q;
    phase_d      = phase_q;
    best_phase_d = best_phase_q;
    best_score_d = best_score_q;
    sc_clear     = 1'b0;
    sc_enable    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // start takes priority; a simultaneous manual write is dropped
        if (start) begin
          clksrc_d    = clksrc_in;
          idx_d       = '0;
          run_score_d = '0;
          run_phase_d = '0;
          state_d     = StApply;
        end else if (manual_set) begin
          phase_d  = manual_phase;
          update_d = 1'b1;
        end
      end
      StApply: begin
        phase_d  = idx_q[PHASE_W-1:0];
        update_d = 1'b1;
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        sc_clear = 1'b1;
        if (settle_last) begin
          state_d = StMeasure;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      StMeasure: begin
        sc_enable = 1'b1;
        if (sc_window_done) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        // Strict compare so ties keep the earlier (lower) phase.
        if (sc_score > run_score_q) begin
          run_score_d = sc_score;
          run_phase_d = idx_q[PHASE_W-1:0];
        end
        if (idx_q == IDX_W'(NSTEPS - 1)) begin
          state_d = StFinalApply;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StApply;
        end
      end
      StFinalApply: begin
        phase_d  = run_phase_q;
        update_d = 1'b1;
        settle_d = '0;
        state_d  = StFinalSettle;
      end
      StFinalSettle: begin
        if (settle_last) begin
          state_d = StDone;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      StDone: begin
        best_phase_d = run_phase_q;
        best_score_d = run_score_q;
        done_d       = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      settle_q     <= '0;
      run_phase_q  <= '0;
      run_score_q  <= '0;
      update_q     <= 1'b0;
      done_q       <= 1'b0;
      clksrc_q     <= 1'b0;
      phase_q      <= '0;
      best_phase_q <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      run_phase_q  <= run_phase_d;
      run_score_q  <= run_score_d;
      update_q     <= update_d;
      done_q       <= done_d;
      clksrc_q     <= clksrc_d;
      phase_q      <= phase_d;
      best_phase_q <= best_phase_d;
      best_score_q <= best_score_d;
    end
  end

  assign update     = update_q;
  assign done       = done_q;
  assign pll_clksrc = clksrc_q;
  assign pll_phase  = phase_q;
  assign busy       = (state_q != StIdle);
  assign best_phase = best_phase_q;
  assign best_score = best_score_q;

endmodule

// File: tb/tb_pll_phase_scanner.sv
// Directed and randomized scans checked against a cycle-timing and scoring model of the scanner.
module tb_pll_phase_scanner;

  localparam int N   = 4;
  localparam int S   = 8;
  localparam int W   = 16;
  localparam int CW  = 4;
  localparam int L   = S + W + 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          clksrc_in = 1'b0;
  logic          manual_set = 1'b0;
  logic [7:0]    manual_phase = 8'h00;
  logic          sample_valid = 1'b0;
  logic          sample_ok = 1'b0;
  logic          update, pll_clksrc, busy, done;
  logic [7:0]    pll_phase, best_phase;
  logic [CW-1:0] best_score;

  int checks = 0;
  int errors = 0;
  int exp_bp = 0;
  int exp_bs = 0;

  always #5 clk = ~clk;

  pll_phase_scanner #(
    .NSTEPS        (N),
    .SETTLE_CYCLES (S),
    .WINDOW_CYCLES (W),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .clksrc_in    (clksrc_in),
    .manual_set   (manual_set),
    .manual_phase (manual_phase),
    .sample_valid (sample_valid),
    .sample_ok    (sample_ok),
    .update       (update),
    .pll_clksrc   (pll_clksrc),
    .pll_phase    (pll_phase),
    .busy         (busy),
    .done         (done),
    .best_phase   (best_phase),
    .best_score   (best_score)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " update"}, 32'(update), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " pll_phase"}, 32'(pll_phase), 32'd0);
    chk({tag, " pll_clksrc"}, 32'(pll_clksrc), 32'd0);
    chk({tag, " best_phase"}, 32'(best_phase), 32'd0);
    chk({tag, " best_score"}, 32'(best_score), 32'd0);
  endtask

  task automatic manual_write(input logic [7:0] ph);
    manual_phase = ph;
    manual_set   = 1'b1;
    @(posedge clk); #1;
    manual_set = 1'b0;
    chk("manual update", 32'(update), 32'd1);
    chk("manual pll_phase", 32'(pll_phase), 32'(ph));
    chk("manual busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("manual update end", 32'(update), 32'd0);
    chk("manual pll_phase hold", 32'(pll_phase), 32'(ph));
  endtask

  // Cycle k=0 drives start; step p updates at k=2+p*L, measures for k in
  // [2+p*L+S, 1+p*L+S+W]; final update at 2+N*L; done seen at 3+N*L+S.
  // mode: 0 random, 1 only phase 2 hits, 2 phases 1 and 3 hit 7 times, 3 no valid samples.
  task automatic run_scan(input logic src, input int mode, input bit both, input int abort_at);
    int  sc[N];
    int  fin, bp, bs, cur, q, r, s;
    bit  in_win, is_upd;
    logic v, o;
    fin = 3 + N * L + S;
    bp  = 0;
    bs  = 0;
    cur = 0;
    q   = 0;
    r   = 0;
    foreach (sc[i]) sc[i] = 0;
    for (int k = 0; k <= fin; k++) begin
      in_win = 1'b0;
      if (k > 0) begin
        @(posedge clk); #1;
        if (k >= 2) begin
          q = (k - 2) / L;
          r = (k - 2) % L;
        end
        if (k == 2 + N * L) begin
          for (int p = 0; p < N; p++) begin
            s = (sc[p] > SAT) ? SAT : sc[p];
            if (s > bs) begin
              bs = s;
              bp = p;
            end
          end
        end
        is_upd = (k >= 2) && (r == 0) && (q <= N);
        chk("busy", 32'(busy), 32'(k < fin));
        chk("done", 32'(done), 32'(k == fin));
        chk("update", 32'(update), 32'(is_upd));
        chk("pll_clksrc", 32'(pll_clksrc), 32'(src));
        if (is_upd) cur = (q < N) ? q : bp;
        if (k >= 2) chk("pll_phase", 32'(pll_phase), 32'(cur));
        if (k == fin - 1) begin
          chk("best_phase held", 32'(best_phase), 32'(exp_bp));
          chk("best_score held", 32'(best_score), 32'(exp_bs));
        end
        if (k == fin) begin
          chk("best_phase", 32'(best_phase), 32'(bp));
          chk("best_score", 32'(best_score), 32'(bs));
        end
        if (k == abort_at) begin
          #2 rstn = 1'b0;
          #1 chk_all_zero("abort");
          start        = 1'b0;
          manual_set   = 1'b0;
          sample_valid = 1'b0;
          sample_ok    = 1'b0;
          return;
        end
        in_win = (k >= 2) && (q < N) && (r >= S) && (r < S + W);
      end
      start        = (k == 0) || (k == 40);
      manual_set   = (k == 0 && both) || (k == 41);
      manual_phase = (k == 0) ? 8'h55 : 8'h99;
      clksrc_in    = (k == 0) ? src : ~src;
      case (mode)
        0: begin
          v = 1'($urandom % 2);
          o = 1'($urandom % 2);
        end
        1: begin
          v = 1'b1;
          o = in_win ? (q == 2) : 1'b1;
        end
        2: begin
          v = 1'b1;
          o = in_win && (q == 1 || q == 3) && (r - S < 7);
        end
        default: begin
          v = 1'b0;
          o = 1'($urandom % 2);
        end
      endcase
      sample_valid = v;
      sample_ok    = o;
      if (in_win && v && o) sc[q]++;
    end
    exp_bp       = bp;
    exp_bs       = bs;
    start        = 1'b0;
    manual_set   = 1'b0;
    sample_valid = 1'b0;
    sample_ok    = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    manual_write(8'h2A);
    run_scan(1'b0, 1, 1'b0, 0);
    chk("phase2 best_phase", 32'(best_phase), 32'd2);
    chk("phase2 best_score", 32'(best_score), 32'd15);
    run_scan(1'b0, 2, 1'b1, 0);
    chk("tie best_phase", 32'(best_phase), 32'd1);
    chk("tie best_score", 32'(best_score), 32'd7);
    run_scan(1'b1, 3, 1'b0, 0);
    chk("zero best_phase", 32'(best_phase), 32'd0);
    chk("zero best_score", 32'(best_score), 32'd0);
    run_scan(1'b0, 1, 1'b0, 0);
    run_scan(1'b1, 0, 1'b0, 2 + L + S + 3);

    repeat (3) begin
      @(posedge clk); #1;
      chk("in reset update", 32'(update), 32'd0);
      chk("in reset done", 32'(done), 32'd0);
      chk("in reset busy", 32'(busy), 32'd0);
    end
    rstn   = 1'b1;
    exp_bp = 0;
    exp_bs = 0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post reset update", 32'(update), 32'd0);
      chk("post reset done", 32'(done), 32'd0);
    end

    run_scan(1'b1, 0, 1'b0, 0);
    run_scan(1'b0, 0, 1'b0, 0);
    manual_write(8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
